// File: rtl/object_position_counter_if.sv
// Object position counter bus: direction/load controls in, coordinates and pulses out.
// The master drives controls; the counter (slave) drives coordinates and status pulses.
interface object_position_counter_if #(
    parameter int unsigned X_WIDTH = 10,
    parameter int unsigned Y_WIDTH = 10
);
    logic [3:0]         dir;
    logic               freeze;
    logic               load;
    logic [X_WIDTH-1:0] load_x;
    logic [Y_WIDTH-1:0] load_y;
    logic [X_WIDTH-1:0] x_pos;
    logic [Y_WIDTH-1:0] y_pos;
    logic               step;
    logic               x_edge;
    logic               y_edge;

    modport master (
        output dir, freeze, load, load_x, load_y,
        input  x_pos, y_pos, step, x_edge, y_edge
    );

    modport slave (
        input  dir, freeze, load, load_x, load_y,
        output x_pos, y_pos, step, x_edge, y_edge
    );
endinterface

// File: rtl/object_position_counter.sv
// Prescaled X/Y position counter for one Pong screen object, limited to a programmable field.
// Define OBJECT_POS_WRAP_EN to wrap blocked moves to the opposite limit instead of saturating.
module object_position_counter #(
    parameter int unsigned X_WIDTH  = 10,
    parameter int unsigned Y_WIDTH  = 10,
    parameter int unsigned X_MIN    = 0,
    parameter int unsigned X_MAX    = 639,
    parameter int unsigned Y_MIN    = 0,
    parameter int unsigned Y_MAX    = 479,
    parameter int unsigned X_INIT   = 320,
    parameter int unsigned Y_INIT   = 240,
    parameter int unsigned TICK_DIV = 833333
) (
    input  logic                      clk,
    input  logic                      rstn,
    object_position_counter_if.slave  bus
);

    localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [X_WIDTH-1:0] XMIN     = X_WIDTH'(X_MIN);
    localparam logic [X_WIDTH-1:0] XMAX     = X_WIDTH'(X_MAX);
    localparam logic [X_WIDTH-1:0] XINIT    = X_WIDTH'(X_INIT);
    localparam logic [Y_WIDTH-1:0] YMIN     = Y_WIDTH'(Y_MIN);
    localparam logic [Y_WIDTH-1:0] YMAX     = Y_WIDTH'(Y_MAX);
    localparam logic [Y_WIDTH-1:0] YINIT    = Y_WIDTH'(Y_INIT);

    logic [CNT_W-1:0]   tick_cnt_q, tick_cnt_d;
    logic [X_WIDTH-1:0] x_pos_q, x_pos_d;
    logic [Y_WIDTH-1:0] y_pos_q, y_pos_d;
    logic               step_q, step_d;
    logic               x_edge_q, x_edge_d;
    logic               y_edge_q, y_edge_d;
    logic               tick_now;

    // v < MIN is tested as v+1 <= MIN so a zero lower limit never yields a constant compare
    function automatic logic [X_WIDTH-1:0] clamp_x(input logic [X_WIDTH-1:0] v);
        logic [X_WIDTH:0] v_inc;
        v_inc = {1'b0, v} + (X_WIDTH+1)'(1);
        if (v_inc <= {1'b0, XMIN}) begin
            clamp_x = XMIN;
        end else if (v > XMAX) begin
            clamp_x = XMAX;
        end else begin
            clamp_x = v;
        end
    endfunction

    function automatic logic [Y_WIDTH-1:0] clamp_y(input logic [Y_WIDTH-1:0] v);
        logic [Y_WIDTH:0] v_inc;
        v_inc = {1'b0, v} + (Y_WIDTH+1)'(1);
        if (v_inc <= {1'b0, YMIN}) begin
            clamp_y = YMIN;
        end else if (v > YMAX) begin
            clamp_y = YMAX;
        end else begin
            clamp_y = v;
        end
    endfunction

    assign tick_now = (tick_cnt_q == CNT_LAST) && !bus.freeze;

    always_comb begin
        tick_cnt_d = tick_cnt_q;
        x_pos_d    = x_pos_q;
        y_pos_d    = y_pos_q;
        step_d     = 1'b0;
        x_edge_d   = 1'b0;
        y_edge_d   = 1'b0;

        if (bus.load) begin
            x_pos_d    = clamp_x(bus.load_x);
            y_pos_d    = clamp_y(bus.load_y);
            tick_cnt_d = '0;
        end else if (tick_now) begin
            tick_cnt_d = '0;
            step_d     = 1'b1;

            if (bus.dir[0]) begin
                if (bus.dir[1]) begin
                    if (x_pos_q < XMAX) begin
                        x_pos_d = x_pos_q + X_WIDTH'(1);
                    end else begin
                        x_edge_d = 1'b1;
`ifdef OBJECT_POS_WRAP_EN
                        x_pos_d  = XMIN;
`endif
                    end
                end else begin
                    if (x_pos_q > XMIN) begin
                        x_pos_d = x_pos_q - X_WIDTH'(1);
                    end else begin
                        x_edge_d = 1'b1;
`ifdef OBJECT_POS_WRAP_EN
                        x_pos_d  = XMAX;
`endif
                    end
                end
            end

            if (bus.dir[2]) begin
                if (bus.dir[3]) begin
                    if (y_pos_q < YMAX) begin
                        y_pos_d = y_pos_q + Y_WIDTH'(1);
                    end else begin
                        y_edge_d = 1'b1;
`ifdef OBJECT_POS_WRAP_EN
                        y_pos_d  = YMIN;
`endif
                    end
                end else begin
                    if (y_pos_q > YMIN) begin
                        y_pos_d = y_pos_q - Y_WIDTH'(1);
                    end else begin
                        y_edge_d = 1'b1;
`ifdef OBJECT_POS_WRAP_EN
                        y_pos_d  = YMAX;
`endif
                    end
                end
            end
        end else if (!bus.freeze) begin
            tick_cnt_d = tick_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            tick_cnt_q <= '0;
            x_pos_q    <= XINIT;
            y_pos_q    <= YINIT;
            step_q     <= 1'b0;
            x_edge_q   <= 1'b0;
            y_edge_q   <= 1'b0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            x_pos_q    <= x_pos_d;
            y_pos_q    <= y_pos_d;
            step_q     <= step_d;
            x_edge_q   <= x_edge_d;
            y_edge_q   <= y_edge_d;
        end
    end

    assign bus.x_pos  = x_pos_q;
    assign bus.y_pos  = y_pos_q;
    assign bus.step   = step_q;
    assign bus.x_edge = x_edge_q;
    assign bus.y_edge = y_edge_q;

endmodule

// File: tb/tb_object_position_counter.sv
// Directed bench for object_position_counter with TICK_DIV=4 and X_MIN=4.
// Expected values are hand-derived per cycle; honours OBJECT_POS_WRAP_EN if defined.
module tb_object_position_counter;

    logic clk;
    logic rstn;
    int   n_checks;
    int   n_errors;

    object_position_counter_if #(.X_WIDTH(10), .Y_WIDTH(10)) bus ();

    object_position_counter #(
        .X_WIDTH (10),
        .Y_WIDTH (10),
        .X_MIN   (4),
        .X_MAX   (639),
        .Y_MIN   (0),
        .Y_MAX   (479),
        .X_INIT  (320),
        .Y_INIT  (240),
        .TICK_DIV(4)
    ) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance one clock, then check all outputs just after the edge.
    task automatic cyc_chk(input string tag, input int s, input int xe, input int ye,
                           input int x, input int y);
        @(posedge clk);
        #1;
        chk({tag, ".step"},   32'(bus.step),   32'(s));
        chk({tag, ".x_edge"}, 32'(bus.x_edge), 32'(xe));
        chk({tag, ".y_edge"}, 32'(bus.y_edge), 32'(ye));
        chk({tag, ".x_pos"},  32'(bus.x_pos),  32'(x));
        chk({tag, ".y_pos"},  32'(bus.y_pos),  32'(y));
    endtask

    int x_exp;
    int y_exp;

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        rstn       = 1'b0;
        bus.dir    = 4'b0000;
        bus.freeze = 1'b0;
        bus.load   = 1'b0;
        bus.load_x = '0;
        bus.load_y = '0;

        cyc_chk("reset0", 0, 0, 0, 320, 240);
        cyc_chk("reset1", 0, 0, 0, 320, 240);
        rstn = 1'b1;

        // dir=0000: step every 4th cycle, no movement, no edge pulses
        for (int k = 1; k <= 12; k++)
            cyc_chk("idle", (k % 4 == 0) ? 1 : 0, 0, 0, 320, 240);

        // dir=1100: Y increments once per tick
        bus.dir = 4'b1100;
        y_exp = 240;
        for (int k = 1; k <= 12; k++) begin
            if (k % 4 == 0) y_exp++;
            cyc_chk("yup", (k % 4 == 0) ? 1 : 0, 0, 0, 320, y_exp);
        end

        // load 5/1, X decrements to X_MIN=4, then blocked at the limit
        bus.dir    = 4'b0001;
        bus.load   = 1'b1;
        bus.load_x = 10'd5;
        bus.load_y = 10'd1;
        cyc_chk("load51", 0, 0, 0, 5, 1);
        bus.load = 1'b0;
        for (int k = 1; k <= 3; k++) cyc_chk("xdn1", 0, 0, 0, 5, 1);
        cyc_chk("xdn1_tick", 1, 0, 0, 4, 1);
        for (int k = 1; k <= 3; k++) cyc_chk("xdn2", 0, 0, 0, 4, 1);
`ifdef OBJECT_POS_WRAP_EN
        x_exp = 639;
`else
        x_exp = 4;
`endif
        cyc_chk("xmin_block", 1, 1, 0, x_exp, 1);

        // mid-period load above limits clamps and restarts the prescaler
        bus.dir = 4'b0000;
        cyc_chk("pre_load1", 0, 0, 0, x_exp, 1);
        cyc_chk("pre_load2", 0, 0, 0, x_exp, 1);
        bus.load   = 1'b1;
        bus.load_x = 10'd700;
        bus.load_y = 10'd500;
        cyc_chk("load_clamp", 0, 0, 0, 639, 479);
        bus.load = 1'b0;
        for (int k = 1; k <= 3; k++) cyc_chk("after_load", 0, 0, 0, 639, 479);
        cyc_chk("after_load_tick", 1, 0, 0, 639, 479);

        // freeze at tick_cnt=2 for 10 cycles; dir changed while frozen
        cyc_chk("pre_frz1", 0, 0, 0, 639, 479);
        cyc_chk("pre_frz2", 0, 0, 0, 639, 479);
        bus.freeze = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            if (k == 5) bus.dir = 4'b0101;
            cyc_chk("frozen", 0, 0, 0, 639, 479);
        end
        bus.freeze = 1'b0;
        cyc_chk("resume1", 0, 0, 0, 639, 479);
        cyc_chk("resume_tick", 1, 0, 0, 638, 478);

        // freeze in the tick cycle defers the tick to the first unfrozen cycle
        for (int k = 1; k <= 3; k++) cyc_chk("to_tick", 0, 0, 0, 638, 478);
        bus.freeze = 1'b1;
        for (int k = 1; k <= 3; k++) cyc_chk("frz_tick", 0, 0, 0, 638, 478);
        bus.freeze = 1'b0;
        cyc_chk("deferred_tick", 1, 0, 0, 637, 477);

        // load in the tick cycle discards the tick
        for (int k = 1; k <= 3; k++) cyc_chk("to_tick2", 0, 0, 0, 637, 477);
        bus.load   = 1'b1;
        bus.load_x = 10'd100;
        bus.load_y = 10'd200;
        cyc_chk("load_on_tick", 0, 0, 0, 100, 200);
        bus.load = 1'b0;
        for (int k = 1; k <= 3; k++) cyc_chk("post_lt", 0, 0, 0, 100, 200);
        cyc_chk("post_lt_tick", 1, 0, 0, 99, 199);

        // reset at tick_cnt=2 with y=300
        bus.load   = 1'b1;
        bus.load_x = 10'd10;
        bus.load_y = 10'd300;
        cyc_chk("load_300", 0, 0, 0, 10, 300);
        bus.load = 1'b0;
        cyc_chk("pre_rst1", 0, 0, 0, 10, 300);
        cyc_chk("pre_rst2", 0, 0, 0, 10, 300);
        rstn = 1'b0;
        cyc_chk("mid_reset", 0, 0, 0, 320, 240);
        rstn = 1'b1;
        for (int k = 1; k <= 3; k++) cyc_chk("post_rst", 0, 0, 0, 320, 240);
        cyc_chk("post_rst_tick", 1, 0, 0, 319, 239);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
